mips_state_dumper: RTL
======================

# mips_state_dumper

Hardware read-out engine for the single-cycle MIPS core: on a start pulse it walks the register file, then data memory, through dedicated read ports and streams every word out on a valid/ready interface. It is the on-chip counterpart of the bench-side state load: where preload writes architectural state in, this block reads the final state out word by word for capture by a host or a checker. It sits beside the core, sharing only the register-file and data-memory read ports, and is idle during normal execution.

## Interface
- REG_COUNT, 32, number of register-file entries dumped
- MEM_DEPTH, 256, number of data-memory words dumped
- DATA_W, 32, word width
- MEM_ADDR_W, 8, data-memory address width (2**MEM_ADDR_W >= MEM_DEPTH)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin dump; sampled only when idle
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse after last word accepted
- reg_rd_addr  out  5  register-file read address
- reg_rd_data  in  DATA_W  register-file read data, combinational from reg_rd_addr
- mem_rd_addr  out  MEM_ADDR_W  data-memory word address
- mem_rd_data  in  DATA_W  data-memory read data, combinational from mem_rd_addr
- out_valid  out  1  out_* holds a word
- out_ready  in  1  sink accepts word when out_valid && out_ready
- out_data  out  DATA_W  dumped word
- out_src  out  2  00 register, 01 memory, 10 checksum
- out_index  out  MEM_ADDR_W  register number or memory word index

## Operation
- FSM states: IDLE, REGS, MEMS, CSUM, FIN.
- IDLE: start=1 -> REGS, index 0, busy=1. start ignored in every other state.
- REGS: present reg_rd_addr=index; word loaded into output register when slot free (out_valid=0 or handshake this cycle); index increments on load; after loading REG_COUNT-1 -> MEMS, index 0.
- MEMS: same with mem_rd_addr; after MEM_DEPTH-1 -> CSUM if checksum enabled, else FIN.
- CSUM: load checksum word, out_src=10, out_index=0 -> FIN.
- FIN: wait until final word accepted; then done=1 for one cycle, busy=0, -> IDLE.
- out_data/out_src/out_index stable while out_valid=1 and out_ready=0.
- Word count per dump: REG_COUNT+MEM_DEPTH (+1 with checksum).
- Reset values: busy=0, done=0, out_valid=0, out_data=0, out_src=00, out_index=0, reg_rd_addr=0, mem_rd_addr=0, state IDLE.

## Timing
- start sampled at edge N -> busy=1 after edge N; out_valid=1 with register 0 after edge N+1.
- With out_ready held 1: one word per cycle, no bubbles, including REGS->MEMS transition.
- out_ready=0: source stalls; index and read address do not advance.
- done asserts the cycle after the final handshake edge; busy falls same edge; start at that same edge-cycle is ignored, accepted from next cycle.
- rst_n low at any point: all outputs to reset values immediately (asynchronous); in-flight word discarded; no done.
- Read ports are combinational; the block never needs more than one cycle of read latency.

## Configuration
- DUMPER_CHECKSUM_EN defined: after the last memory word, emit one extra word, out_src=10, equal to XOR of all previously emitted words of this dump; accumulator cleared on start.
- Undefined: no CSUM state, no accumulator; out_src=10 never produced; MEMS -> FIN directly.

## Structure
- Shared package: state encoding enum (IDLE/REGS/MEMS/CSUM/FIN), out_src constants (SRC_REG, SRC_MEM, SRC_CSUM).
- One natural sub-module: dump_out_reg, single-entry valid/ready output holding register (load, stall, handshake).
- Top-level ports of core's register file and data memory gain a second read port for the dumper.

## Test plan
- Reset: rst_n=0 -> all outputs at reset values; release, no start -> out_valid stays 0.
- Full dump, out_ready=1, registers preloaded r[i]=i*3, mem[i]=0x1000+i -> 288 words in order; word 5 = 15 src 00; word 32 = 0x1000 src 01 index 0; done one cycle after word 287.
- Backpressure: toggle out_ready every 3 cycles -> identical sequence, out_* stable during every stall.
- start pulsed at word 10 while busy -> ignored; sequence and word count unchanged.
- rst_n low at word 40 -> out_valid=0 at once; new start -> dump restarts at register 0.
- DUMPER_CHECKSUM_EN, all data zero except r[1]=0xA5A5A5A5, mem[3]=0x0F0F0F0F -> 289th word 0xAAAAAAAA, src 10.

Source files
------------

// File: rtl/mips_state_dumper_pkg.sv
// mips_state_dumper_pkg
// Shared definitions for the MIPS state dumper: the dump sequencer state
// encoding, the out_src tag values and a small index helper.
// Optional feature macro: DUMPER_CHECKSUM_EN (the CSUM state is only
// reached when the macro is defined).
package mips_state_dumper_pkg;

  // Dump sequencer states: registers first, then memory, then the optional
  // checksum word, then a wait for the final word to drain.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REGS = 3'd1,
    MEMS = 3'd2,
    CSUM = 3'd3,
    FIN  = 3'd4
  } dump_state_e;

  // Tag carried on out_src telling the host where the word came from.
  localparam logic [1:0] SRC_REG  = 2'b00;
  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [1:0] SRC_CSUM = 2'b10;

  // True when idx addresses the final entry of a region holding count words.
  function automatic logic is_last(input int unsigned idx, input int unsigned count);
    return idx == (count - 1);
  endfunction

endpackage

// File: rtl/mips_state_dumper_if.sv
// mips_state_dumper_if
// Valid/ready word stream leaving the state dumper.
//   out_valid  : out_* holds a word
//   out_ready  : sink accepts the word when out_valid && out_ready
//   out_data   : dumped word
//   out_src    : 00 register, 01 memory, 10 checksum
//   out_index  : register number or memory word index
// Modports: master (the dumper drives the stream), slave (the sink).
interface mips_state_dumper_if #(
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 8
);

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic [1:0]            out_src;
  logic [MEM_ADDR_W-1:0] out_index;

  modport master (
    output out_valid,
    output out_data,
    output out_src,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_src,
    input  out_index,
    output out_ready
  );

endinterface

// File: rtl/mips_state_dumper_dump_out_reg.sv
// dump_out_reg
// Single-entry valid/ready holding register for the dump stream.
//   clk, rst_n       : clock, asynchronous active-low reset
//   load             : capture load_* this cycle (only asserted when slot_free)
//   load_data/src/index : word and its tags to capture
//   out_ready        : sink ready
//   out_valid/data/src/index : registered stream outputs
//   slot_free        : register empty or being emptied by a handshake this cycle
// The outputs only change on a load or when the held word is accepted, so
// they are stable for the whole of any stall.
module dump_out_reg #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [1:0]        load_src,
  input  logic [IDX_W-1:0]  load_index,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic [IDX_W-1:0]  out_index,
  output logic              slot_free
);

  // A new word may enter when nothing is held or the held word leaves now;
  // this is what lets the stream run at one word per cycle with no bubbles.
  assign slot_free = !out_valid || out_ready;

  // Holding register: a load overwrites the slot, otherwise a handshake
  // empties it. Data fields are left untouched when the slot empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'b00;
      out_index <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_src   <= load_src;
      out_index <= load_index;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mips_state_dumper.sv
// mips_state_dumper
// Read-out engine for the single-cycle MIPS core. On a start pulse it walks
// the register file and then data memory through dedicated combinational
// read ports and streams every word out on a valid/ready interface.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a dump (sampled only when idle)
//   busy         : dump in progress
//   done         : one-cycle pulse after the last word is accepted
//   reg_rd_addr / reg_rd_data : register-file read port
//   mem_rd_addr / mem_rd_data : data-memory read port
//   dump         : output word stream (mips_state_dumper_if.master)
// Optional feature macro: DUMPER_CHECKSUM_EN -- when defined, one extra word
// (out_src=10) equal to the XOR of every word of the dump is appended.
module mips_state_dumper
  import mips_state_dumper_pkg::*;
#(
  parameter int REG_COUNT  = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            reg_rd_addr,
  input  logic [DATA_W-1:0]     reg_rd_data,
  output logic [MEM_ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0]     mem_rd_data,
  mips_state_dumper_if.master   dump
);

  localparam int IDX_W = MEM_ADDR_W;

  dump_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;

  logic              load;
  logic [DATA_W-1:0] load_data;
  logic [1:0]        load_src;
  logic [IDX_W-1:0]  load_index;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_src;
  logic [IDX_W-1:0]  out_index;
  logic              slot_free;

`ifdef DUMPER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
`endif

  // Read addresses come straight from the walking index so the read data is
  // available in the same cycle it is loaded into the output register.
  assign reg_rd_addr = (state_q == REGS) ? idx_q[4:0] : 5'd0;
  assign mem_rd_addr = (state_q == MEMS) ? idx_q : '0;

  assign busy = (state_q != IDLE);
  assign done = done_q;

  assign dump.out_valid = out_valid;
  assign dump.out_data  = out_data;
  assign dump.out_src   = out_src;
  assign dump.out_index = out_index;

  // State, index and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Sequencer: each region advances its index only when a word actually
  // enters the output register, so backpressure freezes the walk. FIN waits
  // for the last word to be accepted before pulsing done.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    load       = 1'b0;
    load_data  = reg_rd_data;
    load_src   = SRC_REG;
    load_index = idx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REGS;
          idx_d   = '0;
        end
      end

      REGS: begin
        if (slot_free) begin
          load = 1'b1;
          if (is_last(32'(idx_q), REG_COUNT)) begin
            state_d = MEMS;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      MEMS: begin
        load_data = mem_rd_data;
        load_src  = SRC_MEM;
        if (slot_free) begin
          load = 1'b1;
          if (is_last(32'(idx_q), MEM_DEPTH)) begin
`ifdef DUMPER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = FIN;
`endif
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

`ifdef DUMPER_CHECKSUM_EN
      CSUM: begin
        load_data  = csum_q;
        load_src   = SRC_CSUM;
        load_index = '0;
        if (slot_free) begin
          load    = 1'b1;
          state_d = FIN;
        end
      end
`endif

      FIN: begin
        if (out_valid && dump.out_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef DUMPER_CHECKSUM_EN
  // Running XOR of every register and memory word loaded in this dump;
  // cleared when a new dump is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (state_q == IDLE && start) begin
      csum_q <= '0;
    end else if (load && (state_q == REGS || state_q == MEMS)) begin
      csum_q <= csum_q ^ load_data;
    end
  end
`endif

  dump_out_reg #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  (load_data),
    .load_src   (load_src),
    .load_index (load_index),
    .out_ready  (dump.out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_index  (out_index),
    .slot_free  (slot_free)
  );

endmodule
